// File: rtl/prim_ram_cfg_ctrl.sv
// Per-channel RAM configuration holder with a hold/idle/settle update handshake.
// Optional WAIT_IDLE timeout enabled by defining PRIM_RAM_CFG_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no update in flight, req_i sampled
// WAIT_IDLE | target RAM held, waiting for ram_idle_i[idx]
// APPLY     | captured cfg written into the target channel
// SETTLE    | target still held, counting down before ack
// ERR       | one-cycle ack with err_o, nothing changed
module prim_ram_cfg_ctrl #(
  parameter int unsigned NumRams       = 4,
  parameter int unsigned CfgW          = 4,
  parameter int unsigned SettleCycles  = 2,
  parameter logic [CfgW-1:0] CfgDefault = '0,
  parameter int unsigned TimeoutCycles = 16,
  localparam int unsigned IdxW = (NumRams > 1) ? $clog2(NumRams) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic [IdxW-1:0]          idx_i,
  input  logic                     cfg_en_i,
  input  logic [CfgW-1:0]          cfg_i,
  input  logic [NumRams-1:0]       ram_idle_i,
  output logic [NumRams-1:0]       ram_hold_o,
  output logic [NumRams-1:0]       ram_cfg_en_o,
  output logic [NumRams*CfgW-1:0]  ram_cfg_o,
  output logic                     busy_o,
  output logic                     ack_o,
  output logic                     err_o
);

  localparam int unsigned CntMax = (TimeoutCycles > SettleCycles) ? TimeoutCycles : SettleCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_IDLE = 3'd1,
    APPLY     = 3'd2,
    SETTLE    = 3'd3,
    ERR       = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q;
  logic            cfg_en_new_q;
  logic [CfgW-1:0] cfg_new_q;
  logic            capture;
  logic            idx_ok;

  logic [NumRams-1:0][CfgW-1:0] cfg_q;
  logic [NumRams-1:0]           cfg_en_q;

  assign idx_ok = ({1'b0, idx_i} < (IdxW+1)'(NumRams));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      cfg_en_new_q <= 1'b0;
      cfg_new_q    <= '0;
      cfg_en_q     <= '0;
      cfg_q        <= {NumRams{CfgDefault}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q        <= idx_i;
        cfg_en_new_q <= cfg_en_i;
        cfg_new_q    <= cfg_i;
      end
      if (state_q == APPLY) begin
        cfg_q[idx_q]    <= cfg_new_q;
        cfg_en_q[idx_q] <= cfg_en_new_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if (idx_ok) begin
            capture = 1'b1;
            cnt_d   = CntW'(TimeoutCycles);
            state_d = WAIT_IDLE;
          end else begin
            state_d = ERR;
          end
        end
      end
      WAIT_IDLE: begin
        if (ram_idle_i[idx_q]) begin
          state_d = APPLY;
`ifdef PRIM_RAM_CFG_TIMEOUT_EN
        end else if (cnt_q == '0) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q - 1'b1;
`endif
        end
      end
      APPLY: begin
        cnt_d   = CntW'(SettleCycles - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decodes of registered state only; hold covers exactly one channel.
  always_comb begin
    ram_hold_o = '0;
    if (state_q == WAIT_IDLE || state_q == APPLY || state_q == SETTLE) begin
      ram_hold_o[idx_q] = 1'b1;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign ack_o        = (state_q == ERR) || (state_q == SETTLE && cnt_q == '0);
  assign err_o        = (state_q == ERR);
  assign ram_cfg_o    = cfg_q;
  assign ram_cfg_en_o = cfg_en_q;

endmodule

// File: tb/tb_prim_ram_cfg_ctrl.sv
// Directed bench for prim_ram_cfg_ctrl: a 4-channel and a 3-channel instance,
// both with cfg default 4'h5.
module tb_prim_ram_cfg_ctrl;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i;
  logic        req_a, req_b;
  logic [1:0]  idx;
  logic        cfg_en;
  logic [3:0]  cfg;
  logic [3:0]  idle;

  logic [3:0]  hold_a, en_a;
  logic [15:0] cfgo_a;
  logic        busy_a, ack_a, err_a;
  logic [2:0]  hold_b, en_b;
  logic [11:0] cfgo_b;
  logic        busy_b, ack_b, err_b;

  int errors = 0;
  int checks = 0;

  logic [3:0] m_cfg [4];
  logic [3:0] m_en;

  prim_ram_cfg_ctrl #(.NumRams(4), .CfgW(4), .SettleCycles(2), .CfgDefault(4'h5), .TimeoutCycles(16)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_a), .idx_i(idx), .cfg_en_i(cfg_en), .cfg_i(cfg),
    .ram_idle_i(idle), .ram_hold_o(hold_a), .ram_cfg_en_o(en_a), .ram_cfg_o(cfgo_a),
    .busy_o(busy_a), .ack_o(ack_a), .err_o(err_a));

  prim_ram_cfg_ctrl #(.NumRams(3), .CfgW(4), .SettleCycles(2), .CfgDefault(4'h5), .TimeoutCycles(16)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_b), .idx_i(idx), .cfg_en_i(cfg_en), .cfg_i(cfg),
    .ram_idle_i(idle[2:0]), .ram_hold_o(hold_b), .ram_cfg_en_o(en_b), .ram_cfg_o(cfgo_b),
    .busy_o(busy_b), .ack_o(ack_b), .err_o(err_b));

  function automatic logic [15:0] exp_cfg();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = m_cfg[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cfg[i] = 4'h5;
    m_en = 4'h0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_a = 1'b0; req_b = 1'b0; idx = 2'd0; cfg_en = 1'b0; cfg = 4'h0; idle = 4'hF;
    tick(); tick();
    model_reset();
    checks++; if (cfgo_a !== 16'h5555) begin errors++; $display("FAIL reset_cfg_a: got %h exp 5555", cfgo_a); end
    checks++; if (cfgo_b !== 12'h555) begin errors++; $display("FAIL reset_cfg_b: got %h exp 555", cfgo_b); end
    checks++; if ({en_a, hold_a} !== 8'h00) begin errors++; $display("FAIL reset_en_hold: got %h exp 00", {en_a, hold_a}); end
    checks++; if ({busy_a, ack_a, err_a} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {busy_a, ack_a, err_a}); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_immediate();
    idx = 2'd2; cfg = 4'hA; cfg_en = 1'b1; idle = 4'hF; req_a = 1'b1;
    tick(); req_a = 1'b0;                                   // T+1
    checks++; if ({busy_a, hold_a} !== 5'b1_0100) begin errors++; $display("FAIL imm_t1_busy_hold: got %b exp 10100", {busy_a, hold_a}); end
    checks++; if (cfgo_a !== exp_cfg()) begin errors++; $display("FAIL imm_t1_cfg_old: got %h exp %h", cfgo_a, exp_cfg()); end
    tick();                                                 // T+2
    checks++; if ({hold_a, ack_a} !== 5'b0100_0) begin errors++; $display("FAIL imm_t2_hold_ack: got %b exp 01000", {hold_a, ack_a}); end
    tick();                                                 // T+3
    m_cfg[2] = 4'hA; m_en[2] = 1'b1;
    checks++; if (cfgo_a !== exp_cfg()) begin errors++; $display("FAIL imm_t3_cfg: got %h exp %h", cfgo_a, exp_cfg()); end
    checks++; if (en_a !== m_en) begin errors++; $display("FAIL imm_t3_en: got %b exp %b", en_a, m_en); end
    checks++; if ({hold_a, ack_a} !== 5'b0100_0) begin errors++; $display("FAIL imm_t3_hold_ack: got %b exp 01000", {hold_a, ack_a}); end
    idx = 2'd0; cfg = 4'h3; cfg_en = 1'b0; req_a = 1'b1;   // ignored while busy
    tick();                                                 // T+4
    checks++; if ({ack_a, err_a, hold_a} !== 6'b10_0100) begin errors++; $display("FAIL imm_t4_ack: got %b exp 100100", {ack_a, err_a, hold_a}); end
    tick();                                                 // T+5, req still high
    checks++; if ({busy_a, ack_a} !== 2'b00) begin errors++; $display("FAIL imm_t5_idle: got %b exp 00", {busy_a, ack_a}); end
  endtask

  task automatic test_back_to_back();
    tick(); req_a = 1'b0;                                   // T'+1 of request taken at T+5
    checks++; if ({busy_a, hold_a} !== 5'b1_0001) begin errors++; $display("FAIL b2b_accept: got %b exp 10001", {busy_a, hold_a}); end
    tick(); tick(); tick();                                 // T'+4
    m_cfg[0] = 4'h3; m_en[0] = 1'b0;
    checks++; if ({ack_a, err_a} !== 2'b10) begin errors++; $display("FAIL b2b_ack: got %b exp 10", {ack_a, err_a}); end
    checks++; if (cfgo_a !== exp_cfg()) begin errors++; $display("FAIL b2b_cfg: got %h exp %h", cfgo_a, exp_cfg()); end
    tick();
  endtask

  task automatic test_delayed_idle();
    int first_ack;
    int n_ack;
    first_ack = 0; n_ack = 0;
    idle = 4'b1101; idx = 2'd1; cfg = 4'h6; cfg_en = 1'b1; req_a = 1'b1;
    tick(); req_a = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 2) begin idx = 2'd3; cfg = 4'hF; req_a = 1'b1; end
      if (c == 3) req_a = 1'b0;
      if (c == 6) idle = 4'hF;
      if (c == 5) begin
        checks++; if (hold_a !== 4'b0010) begin errors++; $display("FAIL dly_hold: got %b exp 0010", hold_a); end
      end
      if (ack_a) begin
        n_ack++;
        if (first_ack == 0) first_ack = c;
      end
      tick();
    end
    m_cfg[1] = 4'h6; m_en[1] = 1'b1;
    checks++; if (first_ack !== 9) begin errors++; $display("FAIL dly_ack_cycle: got %0d exp 9", first_ack); end
    checks++; if (n_ack !== 1) begin errors++; $display("FAIL dly_ack_count: got %0d exp 1", n_ack); end
    checks++; if (cfgo_a !== exp_cfg()) begin errors++; $display("FAIL dly_cfg: got %h exp %h", cfgo_a, exp_cfg()); end
    checks++; if (en_a !== m_en) begin errors++; $display("FAIL dly_en: got %b exp %b", en_a, m_en); end
  endtask

  task automatic test_invalid();
    idx = 2'd3; cfg = 4'h9; cfg_en = 1'b1; idle = 4'hF; req_b = 1'b1;
    tick(); req_b = 1'b0;                                   // T+1
    checks++; if ({ack_b, err_b, busy_b} !== 3'b111) begin errors++; $display("FAIL inv_ack_err: got %b exp 111", {ack_b, err_b, busy_b}); end
    checks++; if (hold_b !== 3'b000) begin errors++; $display("FAIL inv_hold: got %b exp 000", hold_b); end
    tick();                                                 // T+2
    checks++; if ({busy_b, ack_b, err_b} !== 3'b000) begin errors++; $display("FAIL inv_done: got %b exp 000", {busy_b, ack_b, err_b}); end
    checks++; if ({cfgo_b, en_b} !== {12'h555, 3'b000}) begin errors++; $display("FAIL inv_cfg: got %h/%b exp 555/000", cfgo_b, en_b); end
  endtask

  task automatic test_reset_mid();
    int n_ack;
    n_ack = 0;
    idx = 2'd0; cfg = 4'hC; cfg_en = 1'b1; idle = 4'hF; req_a = 1'b1;
    tick(); req_a = 1'b0;
    tick(); tick();                                         // T+3, in SETTLE
    checks++; if (cfgo_a[3:0] !== 4'hC) begin errors++; $display("FAIL mid_applied: got %h exp c", cfgo_a[3:0]); end
    rst_i = 1'b1;
    tick();
    model_reset();
    checks++; if (cfgo_a !== exp_cfg()) begin errors++; $display("FAIL mid_rst_cfg: got %h exp %h", cfgo_a, exp_cfg()); end
    checks++; if ({en_a, hold_a, busy_a, ack_a, err_a} !== 11'd0) begin errors++; $display("FAIL mid_rst_outs: got %b exp 0", {en_a, hold_a, busy_a, ack_a, err_a}); end
    rst_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (ack_a) n_ack++;
      tick();
    end
    checks++; if (n_ack !== 0) begin errors++; $display("FAIL mid_no_ack: got %0d exp 0", n_ack); end
  endtask

  task automatic test_timeout();
    int n_ack;
    int hold_bad;
    n_ack = 0; hold_bad = 0;
    idle = 4'b1110; idx = 2'd0; cfg = 4'h7; cfg_en = 1'b1; req_a = 1'b1;
    tick(); req_a = 1'b0;                                   // T+1
`ifdef PRIM_RAM_CFG_TIMEOUT_EN
    for (int c = 1; c < 18; c++) begin
      if (ack_a) n_ack++;
      if (hold_a !== 4'b0001) hold_bad++;
      tick();
    end                                                     // T+18
    checks++; if (n_ack !== 0 || hold_bad !== 0) begin errors++; $display("FAIL to_wait: got acks=%0d holdbad=%0d exp 0/0", n_ack, hold_bad); end
    checks++; if ({ack_a, err_a, busy_a, hold_a} !== 7'b111_0000) begin errors++; $display("FAIL to_ack: got %b exp 1110000", {ack_a, err_a, busy_a, hold_a}); end
    checks++; if (cfgo_a !== exp_cfg() || en_a !== m_en) begin errors++; $display("FAIL to_cfg: got %h/%b exp %h/%b", cfgo_a, en_a, exp_cfg(), m_en); end
    tick();
    checks++; if ({busy_a, ack_a} !== 2'b00) begin errors++; $display("FAIL to_done: got %b exp 00", {busy_a, ack_a}); end
    idle = 4'hF;
`else
    for (int c = 1; c < 31; c++) begin
      if (ack_a) n_ack++;
      if (hold_a !== 4'b0001) hold_bad++;
      tick();
    end                                                     // T+31
    checks++; if (n_ack !== 0 || hold_bad !== 0) begin errors++; $display("FAIL nto_wait: got acks=%0d holdbad=%0d exp 0/0", n_ack, hold_bad); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL nto_busy: got %b exp 1", busy_a); end
    idle = 4'hF;
    tick(); tick(); tick();                                 // APPLY, SETTLE, ack
    m_cfg[0] = 4'h7; m_en[0] = 1'b1;
    checks++; if ({ack_a, err_a} !== 2'b10) begin errors++; $display("FAIL nto_ack: got %b exp 10", {ack_a, err_a}); end
    checks++; if (cfgo_a !== exp_cfg()) begin errors++; $display("FAIL nto_cfg: got %h exp %h", cfgo_a, exp_cfg()); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_back_to_back();
    test_delayed_idle();
    test_invalid();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prim_ram_cfg_ctrl.md
# prim_ram_cfg_ctrl

- Holds run-time configuration (cfg_en plus a CfgW-bit cfg field) for NumRams single-port memory instances.
- Applies each configuration change through a request/acknowledge handshake.
- Holds the target RAM and waits for it to go idle before changing its configuration, then waits a settle period before acknowledging.
- Sits between the configuration CSRs and the RAM wrappers; generalises the fixed 4-bit ram/regfile cfg pair to N channels of parametrised width with safe sequencing.

## Interface
Parameters:
- NumRams, 4: number of RAM channels (≥1).
- CfgW, 4: width of each cfg field (≥1).
- SettleCycles, 2: cycles held after an update before ack (≥1).
- CfgDefault, '0: reset value of every channel's cfg field.
- TimeoutCycles, 16: WAIT_IDLE limit (≥1); used only with the timeout macro.

Ports (IdxW = max(1, $clog2(NumRams))):
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  update request; sampled only in IDLE.
- idx_i  in  IdxW  target channel.
- cfg_en_i  in  1  new cfg_en value.
- cfg_i  in  CfgW  new cfg value.
- ram_idle_i  in  NumRams  per-RAM idle indication.
- ram_hold_o  out  NumRams  per-RAM access hold.
- ram_cfg_en_o  out  NumRams  per-RAM cfg_en.
- ram_cfg_o  out  NumRams*CfgW  per-RAM cfg; channel k occupies bits [k*CfgW +: CfgW].
- busy_o  out  1  high whenever the state is not IDLE.
- ack_o  out  1  one-cycle completion pulse.
- err_o  out  1  qualifies ack_o; high means no update was made.

## Operation
States: IDLE, WAIT_IDLE, APPLY, SETTLE, ERR.

- **IDLE**
  - req_i=1 with idx_i<NumRams: capture idx_i, cfg_en_i and cfg_i; go to WAIT_IDLE.
  - req_i=1 with idx_i≥NumRams: go to ERR.
- **WAIT_IDLE**
  - ram_hold_o[idx]=1.
  - When ram_idle_i[idx]=1, go to APPLY.
- **APPLY**
  - ram_hold_o[idx]=1.
  - Write the captured values into channel idx.
  - Load the settle counter with SettleCycles-1; go to SETTLE.
- **SETTLE**
  - ram_hold_o[idx]=1.
  - Decrement the counter each cycle.
  - When the counter is 0: ack_o=1, err_o=0, go to IDLE.
- **ERR**
  - ack_o=1, err_o=1 for one cycle; go to IDLE.
  - No output changes, no hold.

General rules:
- Only the addressed channel changes; all other channels keep their values and have hold=0.
- req_i is ignored while busy_o=1. The requester must keep req_i low until ack_o, or accept that the request is dropped.
- Writing the same value as the current one still runs the full sequence.
- ram_hold_o, ram_cfg_en_o, ram_cfg_o, ack_o, err_o and busy_o are all registered or pure state decodes.
- At most one bit of ram_hold_o is high at any time.

## Timing
- **Reset** (any cycle, including mid-sequence): next state is IDLE.
  - ram_cfg_o = CfgDefault for every channel; ram_cfg_en_o = 0.
  - ram_hold_o = 0, ack_o = 0, err_o = 0, busy_o = 0.
  - Any in-flight update is abandoned.
- **Valid request accepted at cycle T:**
  - busy_o and hold are high from T+1.
  - If ram_idle_i[idx] is high at T+1: APPLY at T+2, new cfg visible at T+3, ack_o at T+2+SettleCycles. With default SettleCycles=2, ack is at T+4.
  - Each extra cycle with idle low delays all later events by one.
- **Invalid index at T:** ack_o=err_o=1 at T+1; busy_o=1 at T+1 only.
- **After ack:** the next request is accepted at the first cycle after the ack cycle.
- **Idle dropping low after APPLY:** no effect on the sequence.

## Configuration
Macro: PRIM_RAM_CFG_TIMEOUT_EN.

- **Defined:**
  - A counter runs in WAIT_IDLE, cleared on entry.
  - If ram_idle_i[idx] is still low after TimeoutCycles WAIT_IDLE cycles, the next state is ERR (ack_o=err_o=1).
  - Hold is released when leaving WAIT_IDLE; the configuration is not changed.
  - Timeout ack arrives at T+1+TimeoutCycles+1 for a request at T.
- **Undefined:** WAIT_IDLE waits indefinitely, and TimeoutCycles is unused.

## Test plan
- **Reset values:** reset with CfgDefault=4'h5, NumRams=4 → ram_cfg_o=16'h5555, ram_cfg_en_o=0, busy_o=0, ack_o=0.
- **Immediate update:** req at T with idx=2, cfg=4'hA, cfg_en=1, ram_idle_i=4'hF → hold_o=4'b0100 during T+1..T+4, ram_cfg_o[11:8]=A and ram_cfg_en_o[2]=1 from T+3, ack_o=1 err_o=0 at T+4, other channels unchanged.
- **Delayed idle:** ram_idle_i[1] held low for 5 cycles after a req to idx=1 → ack delayed exactly 5 cycles; a second req_i pulsed while busy is ignored.
- **Invalid index:** NumRams=3 and req with idx=3 → ack_o=err_o=1 at T+1, no hold, ram_cfg_o unchanged.
- **Reset mid-operation:** rst_i asserted while in SETTLE → all outputs return to their reset values next cycle; no ack_o.
- **Timeout:** with PRIM_RAM_CFG_TIMEOUT_EN and TimeoutCycles=16, ram_idle_i[0] stuck low → ack_o=err_o=1 at T+18, cfg unchanged, hold released.
